// File: rtl/store_align_unit_pkg.sv
// ----------------------------------------------------------------------------
// store_pkg
// Shared types for the store alignment unit: store size encodings, the
// control FSM state type and the alignment legality check.
// ----------------------------------------------------------------------------
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } sizeT;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } stateT;

    // Bytes may sit anywhere, halfwords need an even address, words need a
    // word-aligned address; the reserved size encoding is never legal.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
        logic legal;
        legal = 1'b0;
        case (size)
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = ~offset[0];
            SZ_WORD: legal = (offset == 2'b00);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// ----------------------------------------------------------------------------
// store_align_unit_if
// Bundles the store-side valid/ready handshake, the data-memory req/ack write
// port and the status outputs of the store alignment unit.
//   slave  : the store alignment unit
//   master : the pipeline / memory side driving stores and acks
// ----------------------------------------------------------------------------
interface store_align_unit_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              StValid;
    logic              StReady;
    logic [ADDR_W-1:0] StAddr;
    logic [31:0]       StData;
    logic [1:0]        StSize;

    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic [3:0]        MemBE;
    logic              MemAck;

    logic              Done;
    logic              AlignErr;
    logic              TimeoutErr;
    logic [ADDR_W-1:0] ErrAddr;

    modport slave (
        input  StValid, StAddr, StData, StSize, MemAck,
        output StReady, MemReq, MemAddr, MemWData, MemBE,
        output Done, AlignErr, TimeoutErr, ErrAddr
    );

    modport master (
        output StValid, StAddr, StData, StSize, MemAck,
        input  StReady, MemReq, MemAddr, MemWData, MemBE,
        input  Done, AlignErr, TimeoutErr, ErrAddr
    );

endinterface

// File: rtl/store_align_unit_lane_mux.sv
// ----------------------------------------------------------------------------
// store_lane_mux
// Combinational big-endian lane builder: replicates the narrowed register
// data across the 32-bit memory word and selects byte enables, where
// be[3] covers bits 31:24 (byte offset 0).
//   size   : store size encoding (store_pkg::sizeT values)
//   offset : byte offset within the word (address bits 1:0)
//   data   : register data
//   wData  : lane-replicated write data
//   be     : byte enables
// ----------------------------------------------------------------------------
module store_lane_mux
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [31:0] wData,
    output logic [3:0]  be
);

    always_comb begin
        wData = '0;
        be    = '0;
        case (size)
            SZ_BYTE: begin
                wData = {4{data[7:0]}};
                be    = 4'b1000 >> offset;
            end
            SZ_HALF: begin
                wData = {2{data[15:0]}};
                be    = offset[1] ? 4'b0011 : 4'b1100;
            end
            SZ_WORD: begin
                wData = data;
                be    = 4'b1111;
            end
            default: begin
                wData = '0;
                be    = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_align_unit.sv
// ----------------------------------------------------------------------------
// store_align_unit
// Store path between EX/MEM and data memory. Accepts one store per
// valid/ready handshake, checks alignment, latches the word address, lane
// data and byte enables, then holds a req/ack write until memory accepts it.
//   Clk, Rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : store_align_unit_if.slave
//                StValid/StReady/StAddr/StData/StSize  store handshake
//                MemReq/MemAddr/MemWData/MemBE/MemAck  memory write port
//                Done/AlignErr/TimeoutErr              one-cycle status pulses
//                ErrAddr                               address of last fault
// Optional: define STORE_TIMEOUT_EN to abandon a request after TIMEOUT
// cycles without ack; otherwise REQ waits indefinitely and TimeoutErr is 0.
// ----------------------------------------------------------------------------
module store_align_unit
    import store_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                Clk,
    input logic                Rst_n,
    store_align_unit_if.slave  bus
);

    stateT             stateQ;
    logic              memReqQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic [31:0]       memWDataQ;
    logic [3:0]        memBEQ;
    logic              doneQ;
    logic              alignErrQ;
    logic [ADDR_W-1:0] errAddrQ;

    logic [31:0]       laneData;
    logic [3:0]        laneBE;
    logic              legal;

    // Lanes are built from the live inputs so they can be registered on accept.
    store_lane_mux uLaneMux (
        .size   (bus.StSize),
        .offset (bus.StAddr[1:0]),
        .data   (bus.StData),
        .wData  (laneData),
        .be     (laneBE)
    );

    assign legal = isAligned(bus.StSize, bus.StAddr[1:0]);

`ifdef STORE_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    // The counter holds the number of unacked REQ cycles already elapsed, so
    // the last allowed cycle is the one where it reads TIMEOUT-1.
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] timeoutCntQ;
    logic            timeoutErrQ;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateQ      <= IDLE;
            memReqQ     <= 1'b0;
            memAddrQ    <= '0;
            memWDataQ   <= '0;
            memBEQ      <= '0;
            doneQ       <= 1'b0;
            alignErrQ   <= 1'b0;
            errAddrQ    <= '0;
`ifdef STORE_TIMEOUT_EN
            timeoutCntQ <= '0;
            timeoutErrQ <= 1'b0;
`endif
        end else begin
            doneQ       <= 1'b0;
            alignErrQ   <= 1'b0;
`ifdef STORE_TIMEOUT_EN
            timeoutErrQ <= 1'b0;
`endif
            case (stateQ)
                IDLE: begin
                    if (bus.StValid) begin
                        if (legal) begin
                            memAddrQ    <= {bus.StAddr[ADDR_W-1:2], 2'b00};
                            memWDataQ   <= laneData;
                            memBEQ      <= laneBE;
                            memReqQ     <= 1'b1;
                            stateQ      <= REQ;
`ifdef STORE_TIMEOUT_EN
                            timeoutCntQ <= '0;
`endif
                        end else begin
                            alignErrQ <= 1'b1;
                            errAddrQ  <= bus.StAddr;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the expiry cycle wins.
                    if (bus.MemAck) begin
                        memReqQ <= 1'b0;
                        doneQ   <= 1'b1;
                        stateQ  <= IDLE;
                    end
`ifdef STORE_TIMEOUT_EN
                    else if (timeoutCntQ == TimeoutLast) begin
                        memReqQ     <= 1'b0;
                        timeoutErrQ <= 1'b1;
                        errAddrQ    <= memAddrQ;
                        stateQ      <= IDLE;
                    end else begin
                        timeoutCntQ <= timeoutCntQ + 1'b1;
                    end
`endif
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign bus.StReady  = (stateQ == IDLE);
    assign bus.MemReq   = memReqQ;
    assign bus.MemAddr  = memAddrQ;
    assign bus.MemWData = memWDataQ;
    assign bus.MemBE    = memBEQ;
    assign bus.Done     = doneQ;
    assign bus.AlignErr = alignErrQ;
    assign bus.ErrAddr  = errAddrQ;

`ifdef STORE_TIMEOUT_EN
    assign bus.TimeoutErr = timeoutErrQ;
`else
    assign bus.TimeoutErr = 1'b0;

    // TIMEOUT only matters when the timeout feature is built in.
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT;
`endif

endmodule
